// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 exception/interrupt controller: trap decision,
// SR/Cause/EPC state, mfc0 read port, mtc0 writes and eret.
module cp0_exc_unit #(
   parameter logic [31:0] PRID      = 32'h0000_2018,
   parameter int          INT_WIDTH = 6
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [4:0]           a1,
   input  logic [4:0]           a2,
   input  logic [31:0]          din,
   input  logic                 we,
   input  logic [31:0]          pc_m,
   input  logic                 bd_m,
   input  logic [4:0]           exc_code_in,
   input  logic [INT_WIDTH-1:0] hw_int,
   input  logic                 eret,
   output logic                 int_req,
   output logic [31:0]          epc_out,
   output logic [31:0]          dout
);

   logic [INT_WIDTH-1:0] im_q, im_d;
   logic [INT_WIDTH-1:0] ip_q, ip_d;
   logic                 exl_q, exl_d;
   logic                 ie_q, ie_d;
   logic                 bd_q, bd_d;
   logic [4:0]           exc_q, exc_d;
   logic [31:0]          epc_q, epc_d;

   logic                 int_pend;
   logic                 exc_pend;
   logic [31:0]          epc_trap;
   logic [31:0]          sr_rd;
   logic [31:0]          cause_rd;

   assign int_pend = (|(hw_int & im_q)) & ie_q & ~exl_q;
   assign exc_pend = (exc_code_in != 5'd0) & ~exl_q;
   assign int_req  = int_pend | exc_pend;
   assign epc_out  = epc_q;

   // Delay-slot faults restart at the branch; low bits forced to word alignment.
   assign epc_trap = (bd_m ? pc_m - 32'd4 : pc_m) & ~32'h3;

   always_comb begin
      im_d  = im_q;
      exl_d = exl_q;
      ie_d  = ie_q;
      bd_d  = bd_q;
      exc_d = exc_q;
      epc_d = epc_q;
      ip_d  = hw_int;
      if (int_req) begin
         exl_d = 1'b1;
         bd_d  = bd_m;
         exc_d = int_pend ? 5'd0 : exc_code_in;
         epc_d = epc_trap;
      end else if (eret) begin
         exl_d = 1'b0;
      end else if (we) begin
         if (a2 == 5'd12) begin
            im_d  = din[10 +: INT_WIDTH];
            exl_d = din[1];
            ie_d  = din[0];
         end else if (a2 == 5'd14) begin
            epc_d = din;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         im_q  <= '0;
         ip_q  <= '0;
         exl_q <= 1'b0;
         ie_q  <= 1'b0;
         bd_q  <= 1'b0;
         exc_q <= 5'd0;
         epc_q <= 32'd0;
      end else begin
         im_q  <= im_d;
         ip_q  <= ip_d;
         exl_q <= exl_d;
         ie_q  <= ie_d;
         bd_q  <= bd_d;
         exc_q <= exc_d;
         epc_q <= epc_d;
      end
   end

   always_comb begin
      sr_rd                   = 32'd0;
      sr_rd[10 +: INT_WIDTH]  = im_q;
      sr_rd[1]                = exl_q;
      sr_rd[0]                = ie_q;
      cause_rd                = 32'd0;
      cause_rd[31]            = bd_q;
      cause_rd[10 +: INT_WIDTH] = ip_q;
      cause_rd[6:2]           = exc_q;
   end

   always_comb begin
      case (a1)
         5'd12:   dout = sr_rd;
         5'd13:   dout = cause_rd;
         5'd14:   dout = epc_q;
         5'd15:   dout = PRID;
         default: dout = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Bench for cp0_exc_unit: directed scenarios plus randomized
// traffic against a register-level reference model.
module tb_cp0_exc_unit;

   localparam logic [31:0] PRID = 32'h0000_2018;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  a1, a2;
   logic [31:0] din;
   logic        we;
   logic [31:0] pc_m;
   logic        bd_m;
   logic [4:0]  exc_code_in;
   logic [5:0]  hw_int;
   logic        eret;
   logic        int_req;
   logic [31:0] epc_out;
   logic [31:0] dout;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] m_sr, m_cause, m_epc;

   always #5 clk = ~clk;

   cp0_exc_unit #(.PRID(PRID), .INT_WIDTH(6)) dut (
      .clk(clk), .reset(reset), .a1(a1), .a2(a2), .din(din),
      .we(we), .pc_m(pc_m), .bd_m(bd_m), .exc_code_in(exc_code_in),
      .hw_int(hw_int), .eret(eret), .int_req(int_req),
      .epc_out(epc_out), .dout(dout)
   );

   function automatic logic m_int_pend();
      return ((hw_int & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
   endfunction

   function automatic logic m_req();
      return m_int_pend() || (exc_code_in != 5'd0 && !m_sr[1]);
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd12:   return m_sr;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         5'd15:   return PRID;
         default: return 32'd0;
      endcase
   endfunction

   task automatic idle();
      a1 = 5'd0; a2 = 5'd0; din = 32'd0; we = 1'b0;
      pc_m = 32'd0; bd_m = 1'b0; exc_code_in = 5'd0;
      hw_int = 6'd0; eret = 1'b0;
   endtask

   // Advance one clock; the model absorbs the same inputs the DUT sees.
   task automatic tick();
      logic        req, ip;
      logic [31:0] pc_adj;
      @(posedge clk);
      if (reset) begin
         m_sr = 0; m_cause = 0; m_epc = 0;
      end else begin
         req = m_req();
         ip  = m_int_pend();
         if (req) begin
            pc_adj  = bd_m ? pc_m - 32'd4 : pc_m;
            m_epc   = pc_adj & 32'hFFFF_FFFC;
            m_sr    = m_sr | 32'h2;
            m_cause = (32'(bd_m) << 31) | (32'(hw_int) << 10)
                    | (32'(ip ? 5'd0 : exc_code_in) << 2);
         end else begin
            m_cause = (m_cause & ~32'h0000_FC00) | (32'(hw_int) << 10);
            if (eret) m_sr = m_sr & ~32'h2;
            else if (we && a2 == 5'd12) m_sr = din & 32'h0000_FC03;
            else if (we && a2 == 5'd14) m_epc = din;
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
      we = 1'b1; a2 = r; din = d;
      tick();
      we = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      a1 = 5'd12; #1;
      n_tests++;
      if (int_req !== 1'b0 || epc_out !== 32'd0 || dout !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_sr: int_req=%b epc=%h dout=%h want 0/0/0",
                  int_req, epc_out, dout);
      end
      a1 = 5'd13; #1;
      n_tests++;
      if (dout !== 32'd0) begin
         n_fail++; $display("FAIL reset_cause: got %h want 0", dout);
      end
      a1 = 5'd14; #1;
      n_tests++;
      if (dout !== 32'd0) begin
         n_fail++; $display("FAIL reset_epc: got %h want 0", dout);
      end
      a1 = 5'd15; #1;
      n_tests++;
      if (dout !== PRID) begin
         n_fail++; $display("FAIL reset_prid: got %h want %h", dout, PRID);
      end
   endtask

   task automatic test_interrupt();
      do_reset();
      mtc0(5'd12, 32'h0000_0401);
      hw_int = 6'b000001; #1;
      n_tests++;
      if (int_req !== 1'b1) begin
         n_fail++; $display("FAIL irq_fire: got %b want 1", int_req);
      end
      tick();
      a1 = 5'd12; #1;
      n_tests++;
      if (int_req !== 1'b0 || dout !== 32'h0000_0403) begin
         n_fail++;
         $display("FAIL irq_exl: int_req=%b sr=%h want 0/00000403",
                  int_req, dout);
      end
      a1 = 5'd13; #1;
      n_tests++;
      if (dout !== 32'h0000_0400) begin
         n_fail++; $display("FAIL irq_cause: got %h want 00000400", dout);
      end
      hw_int = 6'd0;
   endtask

   task automatic test_exception();
      do_reset();
      exc_code_in = 5'd12; pc_m = 32'h0000_3010; #1;
      n_tests++;
      if (int_req !== 1'b1) begin
         n_fail++; $display("FAIL exc_fire: got %b want 1", int_req);
      end
      tick();
      idle(); a1 = 5'd13; #1;
      n_tests++;
      if (epc_out !== 32'h0000_3010 || dout !== 32'h0000_0030) begin
         n_fail++;
         $display("FAIL exc_state: epc=%h cause=%h want 00003010/00000030",
                  epc_out, dout);
      end
   endtask

   task automatic test_delay_slot();
      do_reset();
      exc_code_in = 5'd4; bd_m = 1'b1; pc_m = 32'h0000_3008;
      tick();
      idle(); a1 = 5'd13; #1;
      n_tests++;
      if (epc_out !== 32'h0000_3004 || dout !== 32'h8000_0010) begin
         n_fail++;
         $display("FAIL bd_state: epc=%h cause=%h want 00003004/80000010",
                  epc_out, dout);
      end
      do_reset();
      exc_code_in = 5'd1; bd_m = 1'b1; pc_m = 32'h0000_0002;
      tick();
      idle(); #1;
      n_tests++;
      if (epc_out !== 32'hFFFF_FFFC) begin
         n_fail++; $display("FAIL epc_wrap: got %h want fffffffc", epc_out);
      end
   endtask

   task automatic test_exl_mask();
      do_reset();
      mtc0(5'd12, 32'h0000_0403);
      exc_code_in = 5'd10; hw_int = 6'b000001; #1;
      n_tests++;
      if (int_req !== 1'b0) begin
         n_fail++; $display("FAIL exl_mask: got %b want 0", int_req);
      end
      tick();
      exc_code_in = 5'd0; eret = 1'b1;
      tick();
      eret = 1'b0; a1 = 5'd12; #1;
      n_tests++;
      if (int_req !== 1'b1 || dout !== 32'h0000_0401 || epc_out !== 0) begin
         n_fail++;
         $display("FAIL eret_refire: int_req=%b sr=%h epc=%h want 1/00000401/0",
                  int_req, dout, epc_out);
      end
      tick();
      hw_int = 6'd0;
   endtask

   task automatic test_priority();
      do_reset();
      we = 1'b1; a2 = 5'd14; din = 32'h0000_3100;
      exc_code_in = 5'd8; pc_m = 32'h0000_2000;
      tick();
      idle(); a1 = 5'd13; #1;
      n_tests++;
      if (epc_out !== 32'h0000_2000 || dout[6:2] !== 5'd8) begin
         n_fail++;
         $display("FAIL trap_over_mtc0: epc=%h code=%0d want 00002000/8",
                  epc_out, dout[6:2]);
      end
      do_reset();
      mtc0(5'd12, 32'h0000_0403);
      eret = 1'b1; we = 1'b1; a2 = 5'd12; din = 32'h0000_0402;
      tick();
      idle(); a1 = 5'd12; #1;
      n_tests++;
      if (dout !== 32'h0000_0401) begin
         n_fail++; $display("FAIL eret_over_mtc0: got %h want 00000401", dout);
      end
      mtc0(5'd13, 32'hFFFF_FFFF);
      a1 = 5'd13; #1;
      n_tests++;
      if (dout !== 32'd0) begin
         n_fail++; $display("FAIL cause_ro: got %h want 0", dout);
      end
   endtask

   task automatic test_read_map();
      a1 = 5'd15; #1;
      n_tests++;
      if (dout !== PRID) begin
         n_fail++; $display("FAIL read_prid: got %h want %h", dout, PRID);
      end
      a1 = 5'd7; #1;
      n_tests++;
      if (dout !== 32'd0) begin
         n_fail++; $display("FAIL read_unimpl: got %h want 0", dout);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      mtc0(5'd12, 32'h0000_FC01);
      exc_code_in = 5'd5; pc_m = 32'h0000_4444; hw_int = 6'h3F;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0; idle(); a1 = 5'd12; #1;
      n_tests++;
      if (dout !== 32'd0 || epc_out !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_mid_sr: sr=%h epc=%h want 0/0", dout, epc_out);
      end
      a1 = 5'd13; #1;
      n_tests++;
      if (dout !== 32'd0) begin
         n_fail++; $display("FAIL reset_mid_cause: got %h want 0", dout);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 500; i++) begin
         reset       = ($urandom_range(0, 49) == 0);
         exc_code_in = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
         hw_int      = 6'($urandom);
         we          = ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 4))
            0: a2 = 5'd12;
            1: a2 = 5'd13;
            2: a2 = 5'd14;
            3: a2 = 5'd15;
            default: a2 = 5'($urandom);
         endcase
         din  = $urandom;
         eret = ($urandom_range(0, 5) == 0);
         pc_m = $urandom;
         bd_m = 1'($urandom);
         a1   = ($urandom_range(0, 3) == 0) ? 5'($urandom)
                                             : 5'(12 + $urandom_range(0, 3));
         #1;
         n_tests++;
         if (int_req !== m_req() || epc_out !== m_epc || dout !== m_read(a1)) begin
            n_fail++;
            $display("FAIL rand[%0d]: req=%b epc=%h dout=%h want %b/%h/%h",
                     i, int_req, epc_out, dout, m_req(), m_epc, m_read(a1));
         end
         tick();
      end
      reset = 1'b0;
   endtask

   initial begin
      m_sr = 0; m_cause = 0; m_epc = 0;
      idle();
      reset = 1'b1;
      @(negedge clk);
      test_reset();
      test_interrupt();
      test_exception();
      test_delay_slot();
      test_exl_mask();
      test_priority();
      test_read_map();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
